image_frame_controller: RTL and testbench

Sequences one image frame from the Wishbone slave port into the CNN pixel stream. It decodes the size header, validates it and counts size*size pixels. Pixels are buffered in a small first-word-fall-through FIFO with ready/valid toward the CNN, and the block flags end of frame. It throttles the host through Wishbone ack whenever the CNN back-pressures.

---
 rtl/image_frame_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_image_frame_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_controller.sv
//-----------------------------------------------------------------------------
// image_frame_controller
//
// Moves one image frame from a Wishbone slave port into a ready/valid pixel
// stream for the CNN. The first write of a frame is a size header (edge
// length in dat[9:0]). Once a legal header is seen, exactly size*size pixel
// writes are taken, each buffered in a small first-word-fall-through FIFO.
// Back-pressure from the CNN fills the FIFO, and the host is then stalled
// by withholding wbs_ack_o. A write with dat[31]=1 aborts the frame.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    Wishbone request qualifiers
//   wbs_dat_i               header / pixel (dat[23:0]) / abort (dat[31])
//   wbs_ack_o               one-cycle acknowledge
//   wbs_dat_o               status word, valid only while ack of a read:
//                             [0] frame_busy_o, [1] size_err_o,
//                             [3:2] state, [25:16] image_size_o
//   pix_data_o/valid_o      FIFO head toward the CNN (zero when empty)
//   pix_ready_i             CNN accepts the head pixel
//   pix_last_o              head pixel is the final pixel of the frame
//   image_size_o            latched edge length of the current frame
//   frame_busy_o            frame in progress (state != IDLE)
//   frame_done_o            one-cycle pulse after the last pixel leaves
//   size_err_o              last header was illegal (sticky until a good one)
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a header write
// LOAD   | taking pixel writes, remaining pixels counted down
// DRAIN  | all pixels taken, waiting for the FIFO to empty
// DONE   | single cycle, frame_done_o asserted
//-----------------------------------------------------------------------------
module image_frame_controller #(
    parameter int DATA_WIDTH          = 32,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           wbs_cyc_i,
    input  logic                           wbs_stb_i,
    input  logic                           wbs_we_i,
    input  logic [DATA_WIDTH-1:0]          wbs_dat_i,
    output logic                           wbs_ack_o,
    output logic [DATA_WIDTH-1:0]          wbs_dat_o,
    output logic [23:0]                    pix_data_o,
    output logic                           pix_valid_o,
    input  logic                           pix_ready_i,
    output logic                           pix_last_o,
    output logic [MAX_IMAGE_SIZE_LOG2:0]   image_size_o,
    output logic                           frame_busy_o,
    output logic                           frame_done_o,
    output logic                           size_err_o
);

    localparam int SW = MAX_IMAGE_SIZE_LOG2 + 1;       // size field width
    localparam int RW = 2 * MAX_IMAGE_SIZE_LOG2 + 1;   // remaining counter width
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [SW-1:0] MAX_SZ  = SW'(MAX_IMAGE_SIZE);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic [SW-1:0]         size_q, size_d;
    logic                  err_q, err_d;
    logic [RW-1:0]         remain_q, remain_d;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [24:0]           fifo_mem [FIFO_DEPTH];
    logic [24:0]           fifo_head;

    logic                  req;
    logic                  is_abort;
    logic [SW-1:0]         hdr_size;
    logic                  hdr_ok;
    logic [2*SW-1:0]       size_sq;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  push_last;
    logic [DATA_WIDTH-1:0] status;
    logic                  unused_bits;

    //-------------------------------------------------------------------------
    // Request decode
    //-------------------------------------------------------------------------
    // The ack cycle itself never counts as a new request, so a host that keeps
    // stb high across the ack is not served twice.
    assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign is_abort = wbs_we_i & wbs_dat_i[31];
    assign hdr_size = wbs_dat_i[SW-1:0];
    assign hdr_ok   = (hdr_size != '0) && (hdr_size <= MAX_SZ);
    assign size_sq  = {{SW{1'b0}}, hdr_size} * {{SW{1'b0}}, hdr_size};

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & pix_ready_i;
    assign push_last  = (remain_q == RW'(1));

    assign unused_bits = ^{wbs_dat_i[30:24], size_sq[2*SW-1:RW]};

    always_comb begin
        status          = '0;
        status[0]       = (state_q != ST_IDLE);
        status[1]       = err_q;
        status[3:2]     = state_q;
        status[16 +: SW] = size_q;
    end

    //-------------------------------------------------------------------------
    // Frame sequencer
    //-------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            size_q   <= '0;
            err_q    <= 1'b0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            size_q   <= size_d;
            err_q    <= err_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rdat_d   = '0;
        size_d   = size_q;
        err_d    = err_q;
        remain_d = remain_q;
        push     = 1'b0;
        flush    = 1'b0;

        // No pushes happen in DRAIN, so popping the only entry empties the FIFO.
        if (state_q == ST_DRAIN && pop && count_q == CW'(1)) begin
            state_d = ST_DONE;
        end
        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end

        if (req) begin
            if (!wbs_we_i) begin
                ack_d  = 1'b1;
                rdat_d = status;
            end else if (is_abort) begin
                ack_d = 1'b1;
                if (state_q == ST_LOAD || state_q == ST_DRAIN) begin
                    flush    = 1'b1;
                    remain_d = '0;
                    state_d  = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        ack_d = 1'b1;
                        if (hdr_ok) begin
                            size_d   = hdr_size;
                            err_d    = 1'b0;
                            remain_d = size_sq[RW-1:0];
                            state_d  = ST_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        // Full is judged on the registered count: a pop in this
                        // same cycle does not make room for this write.
                        if (!fifo_full) begin
                            ack_d    = 1'b1;
                            push     = 1'b1;
                            remain_d = remain_q - RW'(1);
                            if (push_last) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                    default: begin
                        // DRAIN and DONE stall ordinary writes.
                    end
                endcase
            end
        end
    end

    //-------------------------------------------------------------------------
    // Pixel FIFO (first-word fall-through)
    //-------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {push_last, wbs_dat_i[23:0]};
        end
    end

    assign fifo_head = fifo_mem[rd_ptr_q];

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = rdat_q;
    assign pix_valid_o  = ~fifo_empty;
    assign pix_data_o   = pix_valid_o ? fifo_head[23:0] : 24'd0;
    assign pix_last_o   = pix_valid_o & fifo_head[24];
    assign image_size_o = size_q;
    assign frame_busy_o = (state_q != ST_IDLE);
    assign frame_done_o = (state_q == ST_DONE);
    assign size_err_o   = err_q;

endmodule

// File: tb/tb_image_frame_controller.sv
`timescale 1ns/1ps
module tb_image_frame_controller;

    localparam logic [31:0] ST_MASK = 32'hFFFF_FFF3;  // state code bits not checked

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [23:0] pdata;
    logic        pvalid;
    logic        pready;
    logic        plast;
    logic [9:0]  isize;
    logic        busy, done, serr;

    image_frame_controller #(
        .DATA_WIDTH(32), .MAX_IMAGE_SIZE(512), .MAX_IMAGE_SIZE_LOG2(9), .FIFO_DEPTH(4)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .pix_data_o(pdata), .pix_valid_o(pvalid), .pix_ready_i(pready), .pix_last_o(plast),
        .image_size_o(isize), .frame_busy_o(busy), .frame_done_o(done), .size_err_o(serr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the frame in progress
    int m_size = 0;
    int m_err  = 0;
    int m_busy = 0;
    int m_total = 0;
    int m_idx  = 0;
    int exp_done = 0;
    int done_cnt = 0;
    int ready_mode = 1;   // 0 low, 1 high, 2 random

    logic [24:0] exp_pix[$];
    logic [31:0] exp_rd[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ready driver: the only process writing pready
    initial begin
        pready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       pready = 1'b0;
                1:       pready = 1'b1;
                default: pready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor / scoreboard
    logic prev_ack = 1'b0, prev_rd_ack = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0; prev_rd_ack = 1'b0; prev_done = 1'b0;
        end else begin
            if (pvalid && pready) begin
                if (exp_pix.size() == 0) begin
                    chk("pix_unexpected", {7'd0, plast, pdata}, 32'hFFFF_FFFF);
                end else begin
                    logic [24:0] e;
                    e = exp_pix.pop_front();
                    chk("pix_data", {8'd0, pdata}, {8'd0, e[23:0]});
                    chk("pix_last", {31'd0, plast}, {31'd0, e[24]});
                end
            end
            if (ack) begin
                chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
                if (!we) begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", dat_o, 32'hFFFF_FFFF);
                    else chk("status_word", dat_o & ST_MASK, exp_rd.pop_front());
                end
            end
            if (prev_rd_ack && !ack) chk("status_cleared", dat_o, 32'd0);
            if (done) begin
                done_cnt++;
                chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
            end
            prev_ack    = ack;
            prev_rd_ack = ack & ~we;
            prev_done   = done;
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] d, input int budget, output bit acked);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; dat_i = d;
        acked = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = 32'd0;
    endtask

    task automatic header(input logic [31:0] d);
        bit ok;
        int sz;
        sz = int'(d[9:0]);
        wb_xfer(1'b1, d, 20, ok);
        chk("hdr_ack", {31'd0, ok}, 32'd1);
        if (sz >= 1 && sz <= 512) begin
            m_size = sz; m_err = 0; m_total = sz * sz; m_idx = 0; m_busy = 1;
        end else begin
            m_err = 1;
        end
        chk("hdr_err", {31'd0, serr}, 32'(m_err));
        chk("hdr_size", {22'd0, isize}, 32'(m_size));
        chk("hdr_busy", {31'd0, busy}, 32'(m_busy));
    endtask

    task automatic px_write(input logic [23:0] p);
        bit ok;
        m_idx++;
        exp_pix.push_back({(m_idx == m_total), p});
        wb_xfer(1'b1, {8'h00, p}, 300, ok);
        chk("px_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic abort_frame();
        bit ok;
        wb_xfer(1'b1, 32'h8000_0000, 20, ok);
        chk("abort_ack", {31'd0, ok}, 32'd1);
        if (m_busy != 0) begin
            exp_pix.delete();
            m_busy = 0;
        end
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, pvalid}, 32'd0);
    endtask

    task automatic rd_status();
        bit ok;
        exp_rd.push_back((32'(m_size) << 16) | (32'(m_err) << 1) | 32'(m_busy));
        wb_xfer(1'b0, 32'd0, 20, ok);
        chk("rd_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_end_timeout", 32'(n < 1000), 32'd1);
        m_busy = 0;
        exp_done++;
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("pix_all_out", 32'(exp_pix.size()), 32'd0);
        chk("end_valid", {31'd0, pvalid}, 32'd0);
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit ok;
        int sz;
        logic [31:0] d;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_pdata", {8'd0, pdata}, 32'd0);
        chk("rst_valid", {31'd0, pvalid}, 32'd0);
        chk("rst_last", {31'd0, plast}, 32'd0);
        chk("rst_size", {22'd0, isize}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, serr}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // reset in the middle of LOAD with 3 pixels buffered
        set_ready(0);
        header(32'd4);
        for (int i = 0; i < 3; i++) px_write(24'($urandom));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, pvalid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_size", {22'd0, isize}, 32'd0);
        exp_pix.delete();
        m_size = 0; m_err = 0; m_busy = 0;
        @(posedge clk); #2;
        rst = 1'b0;

        // 2x2 frame with known pixels
        set_ready(1);
        header(32'd2);
        for (int i = 1; i <= 4; i++) px_write(24'(i));
        finish_frame();

        // illegal headers, then a legal one
        header(32'd0);
        header(32'd513);
        header(32'd4);
        set_ready(2);
        for (int i = 0; i < 16; i++) px_write(24'($urandom));
        finish_frame();

        // back-pressure: FIFO_DEPTH acks, then stall
        set_ready(0);
        header(32'd3);
        for (int i = 1; i <= 4; i++) px_write(24'(i));
        wb_xfer(1'b1, 32'd5, 10, ok);
        chk("stall_5th", {31'd0, ok}, 32'd0);
        chk("stall_valid", {31'd0, pvalid}, 32'd1);
        set_ready(1);
        for (int i = 5; i <= 9; i++) px_write(24'(i));
        finish_frame();

        // abort with pixels buffered
        set_ready(0);
        header(32'd2);
        px_write(24'h00AA01);
        px_write(24'h00AA02);
        abort_frame();
        chk("abort_no_done", 32'(done_cnt), 32'(exp_done));
        rd_status();

        // single-pixel frame
        set_ready(2);
        header(32'd1);
        px_write(24'($urandom));
        finish_frame();

        // random frames with random back-pressure
        for (int k = 0; k < 8; k++) begin
            header(32'($urandom_range(1, 12)));
            for (int i = 0; i < m_total; i++) begin
                px_write(24'($urandom));
                if (i == 0) rd_status();
            end
            finish_frame();
        end

        // random headers: illegal ones leave IDLE, legal ones are aborted
        for (int k = 0; k < 12; k++) begin
            d = $urandom & 32'h7FFF_FFFF;
            if (k % 2 == 0) d[9:0] = 10'($urandom_range(0, 1023));
            header(d);
            if (m_busy != 0) abort_frame();
            rd_status();
        end

        // largest frame: partial load, status, abort
        header(32'd512);
        for (int i = 0; i < 300; i++) px_write(24'($urandom));
        rd_status();
        abort_frame();
        chk("big_no_done", 32'(done_cnt), 32'(exp_done));

        repeat (4) @(posedge clk);
        chk("rd_all_seen", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
